cam_trigger_gen: RTL and testbench
==================================

Name: cam_trigger_gen

Overview:
- Generates the imager exposure trigger (cam_trigger) from the IMU sync pulse train, decimated by a register-programmed ratio, with a register-programmed pulse width in microseconds.
- Sits between the imu_sync synchronizer/register file and the cam_trigger pin.
- Emits a one-cycle start-of-exposure strobe that gates the t_image timestamp capture register.
- Maintains trigger and missed-trigger counters for readback through pio_input.

Parameters:
CLKS_PER_USEC, 125, clock cycles per microsecond (125 MHz); range 2..255; bench uses 4.
DECIM_W, 8, width of imu_decim.
EXP_W, 16, width of exposure_usec.
CNT_W, 16, width of trig_cnt and miss_cnt.

Ports:
c  input  1  clock (clk125 domain); all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
en  input  1  trigger enable (register flag); level.
imu_sync  input  1  IMU sync level, already 2-flop synchronized to c.
imu_decim  input  DECIM_W  fire on every (imu_decim+1)th sync rising edge.
exposure_usec  input  EXP_W  trigger high time in µs; 0 treated as 1.
cam_trigger  output  1  registered trigger to imagers, active-high.
sof_stb  output  1  one-cycle pulse, coincident with the first high cycle of cam_trigger.
busy  output  1  high while in EXPOSE.
trig_cnt  output  CNT_W  issued triggers, wraps modulo 2^CNT_W.
miss_cnt  output  CNT_W  selected sync edges dropped during EXPOSE, saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; cam_trigger, sof_stb, busy=0; trig_cnt, miss_cnt, decim counter, usec prescaler, usec counter, sync history flop all cleared. Reset mid-exposure drops cam_trigger on the next edge; no partial-pulse bookkeeping.
- Edge detect: sync_prev registered each cycle. A rise is imu_sync=1 with sync_prev=0. A level held high produces exactly one rise.
- Decimation counter dcnt (DECIM_W):
  - On a rise with en=1: if dcnt >= imu_decim, the edge is "selected" and dcnt←0; else dcnt←dcnt+1.
  - The >= compare makes a mid-run decrease of imu_decim take effect without waiting for wrap.
  - en=0: dcnt held at 0; no edge is selected.
- States:
  - IDLE: on a selected edge at cycle k, latch exp = (exposure_usec==0 ? 1 : exposure_usec), load prescaler=0 and usec counter=exp, and go to EXPOSE. cam_trigger=1, sof_stb=1, busy=1 all appear registered at cycle k+1. trig_cnt increments at the same edge.
  - EXPOSE: prescaler counts 0..CLKS_PER_USEC-1 and wraps. On wrap, usec counter decrements. When the usec counter is 1 and the prescaler is at CLKS_PER_USEC-1, go to IDLE; cam_trigger drops next cycle. High time is exactly exp*CLKS_PER_USEC cycles.
  - EXPOSE, selected edge arrives: no retrigger; miss_cnt++ (saturating); dcnt resets as normal.
  - EXPOSE, en falls: the exposure completes normally.
  - Final EXPOSE cycle: a selected edge here counts as a miss. An edge in the following IDLE cycle fires normally, giving a minimum low gap of 1 cycle.
- Latched parameters: exposure_usec changes during EXPOSE do not affect the current pulse. imu_decim changes apply at the next rise.
- sof_stb: high for exactly one cycle per trigger; never asserted while cam_trigger is already high.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset then idle: rst_n low 3 cycles; imu_sync toggling, en=0 -> cam_trigger=0, sof_stb=0, trig_cnt=0, miss_cnt=0 throughout.
- Basic pulse (CLKS_PER_USEC=4, imu_decim=0, exposure_usec=5, en=1): sync rise sampled at cycle 10 -> sof_stb=1 only at cycle 11; cam_trigger high cycles 11..30 (20 cycles); trig_cnt=1.
- Decimation (imu_decim=2, exposure_usec=1): 9 sync rises spaced 50 cycles apart -> triggers on rises 3, 6, 9 only; trig_cnt=3; each pulse 4 cycles wide.
- Zero exposure and overlap (exposure_usec=0, then 100 with selected rises 40 cycles apart): first pulse is 4 cycles; during the 400-cycle pulse, following rises are not retriggered -> miss_cnt increments by 1 per rise inside the pulse and cam_trigger stays one continuous pulse.
- Mid-operation disturbances: rst_n low for 1 cycle at cycle 8 of a 20-cycle pulse -> cam_trigger=0 next cycle, counters 0. Separately, en low mid-pulse -> pulse completes at full width, later rises ignored.
- Counter limits: force miss_cnt to 16'hFFFE, then cause 3 misses -> saturates at 16'hFFFF. Force trig_cnt to 16'hFFFF, then one trigger -> wraps to 16'h0000.

Source files
------------

// File: rtl/cam_trigger_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cam_trigger_gen
//  Description : Imager exposure trigger generator. Decimates the IMU sync
//                pulse train, emits a microsecond-timed trigger pulse with a
//                start-of-exposure strobe, and keeps trigger/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_trigger_gen #(
    parameter int CLKS_PER_USEC = 125,
    parameter int DECIM_W       = 8,
    parameter int EXP_W         = 16,
    parameter int CNT_W         = 16
) (
    input  logic               c,
    input  logic               rst_n,
    input  logic               en,
    input  logic               imu_sync,
    input  logic [DECIM_W-1:0] imu_decim,
    input  logic [EXP_W-1:0]   exposure_usec,
    output logic               cam_trigger,
    output logic               sof_stb,
    output logic               busy,
    output logic [CNT_W-1:0]   trig_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int                c_PSC_W   = $clog2(CLKS_PER_USEC);
    localparam logic [c_PSC_W-1:0] c_PSC_LAST = c_PSC_W'(CLKS_PER_USEC - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPOSE = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_sync_prev;
    logic [DECIM_W-1:0]  r_dcnt;
    logic [c_PSC_W-1:0]  r_psc;
    logic [EXP_W-1:0]    r_ucnt;
    logic                r_cam;
    logic                r_sof;
    logic                r_busy;
    logic [CNT_W-1:0]    r_trig_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic                w_rise;
    logic                w_dcnt_hit;
    logic                w_sel;
    logic [EXP_W-1:0]    w_exp;

    // A rise is only counted once per high level; the >= compare lets a
    // lowered ratio take effect immediately instead of after a wrap.
    assign w_rise     = imu_sync & ~r_sync_prev;
    assign w_dcnt_hit = (r_dcnt >= imu_decim);
    assign w_sel      = en & w_rise & w_dcnt_hit;
    assign w_exp      = (exposure_usec == '0) ? EXP_W'(1) : exposure_usec;

    // Sync history and decimation counter; held at zero while disabled.
    always_ff @(posedge c) begin
        if (!rst_n) begin
            r_sync_prev <= 1'b0;
            r_dcnt      <= '0;
        end else begin
            r_sync_prev <= imu_sync;
            if (!en) begin
                r_dcnt <= '0;
            end else if (w_rise) begin
                r_dcnt <= w_dcnt_hit ? '0 : (r_dcnt + DECIM_W'(1));
            end
        end
    end

    // Trigger FSM: registered outputs, usec timing and trigger/miss counters.
    always_ff @(posedge c) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_psc      <= '0;
            r_ucnt     <= '0;
            r_cam      <= 1'b0;
            r_sof      <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_cnt <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_sof <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_sel) begin
                    r_state    <= ST_EXPOSE;
                    r_psc      <= '0;
                    r_ucnt     <= w_exp;
                    r_cam      <= 1'b1;
                    r_sof      <= 1'b1;
                    r_busy     <= 1'b1;
                    r_trig_cnt <= r_trig_cnt + CNT_W'(1);
                end
            end else begin
                // A selected edge during exposure (final cycle included) is
                // dropped and recorded; the running pulse is never extended.
                if (w_sel && (r_miss_cnt != '1)) begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
                if (r_psc == c_PSC_LAST) begin
                    r_psc <= '0;
                    if (r_ucnt == EXP_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_cam   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ucnt <= r_ucnt - EXP_W'(1);
                    end
                end else begin
                    r_psc <= r_psc + c_PSC_W'(1);
                end
            end
        end
    end

    assign cam_trigger = r_cam;
    assign sof_stb     = r_sof;
    assign busy        = r_busy;
    assign trig_cnt    = r_trig_cnt;
    assign miss_cnt    = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cam_trigger_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_trigger_gen
//  Description : Directed self-checking bench for cam_trigger_gen
//                (CLKS_PER_USEC = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cam_trigger_gen;

    localparam int CPU = 4;

    logic        c = 1'b0;
    logic        rst_n;
    logic        en;
    logic        imu_sync;
    logic [7:0]  imu_decim;
    logic [15:0] exposure_usec;
    logic        cam_trigger;
    logic        sof_stb;
    logic        busy;
    logic [15:0] trig_cnt;
    logic [15:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int hi_acc = 0;
    int sof_acc = 0;
    int cam_rises = 0;
    logic prev_cam = 1'b0;

    cam_trigger_gen #(
        .CLKS_PER_USEC (CPU),
        .DECIM_W       (8),
        .EXP_W         (16),
        .CNT_W         (16)
    ) dut (
        .c             (c),
        .rst_n         (rst_n),
        .en            (en),
        .imu_sync      (imu_sync),
        .imu_decim     (imu_decim),
        .exposure_usec (exposure_usec),
        .cam_trigger   (cam_trigger),
        .sof_stb       (sof_stb),
        .busy          (busy),
        .trig_cnt      (trig_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 c = ~c;

    // One clock; outputs sampled 1 ns after the edge and accumulated.
    task automatic tick();
        @(posedge c);
        #1;
        if (cam_trigger && !prev_cam) cam_rises++;
        prev_cam = cam_trigger;
        hi_acc  += int'(cam_trigger);
        sof_acc += int'(sof_stb);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        hi_acc = 0; sof_acc = 0; cam_rises = 0;
    endtask

    // One-cycle sync high; the rising edge is sampled at this tick.
    task automatic rise();
        imu_sync = 1'b1;
        tick();
        imu_sync = 1'b0;
    endtask

    task automatic do_reset();
        imu_sync = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 1000) begin
            tick();
            k++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; imu_sync = 1'b0;
        imu_decim = 8'd0; exposure_usec = 16'd5;

        // ---- reset with sync toggling, then idle with en=0 ----
        for (int i = 0; i < 3; i++) begin
            imu_sync = ~imu_sync;
            tick();
        end
        chk("rst_cam",  32'(cam_trigger), 32'd0);
        chk("rst_sof",  32'(sof_stb),     32'd0);
        chk("rst_busy", 32'(busy),        32'd0);
        chk("rst_trig", 32'(trig_cnt),    32'd0);
        chk("rst_miss", 32'(miss_cnt),    32'd0);
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 8; i++) begin
            imu_sync = ~imu_sync;
            tick();
        end
        imu_sync = 1'b0;
        tick();
        chk("idle_hi",   32'(hi_acc),   32'd0);
        chk("idle_sof",  32'(sof_acc),  32'd0);
        chk("idle_trig", 32'(trig_cnt), 32'd0);

        // ---- basic 5 us pulse, sync held high after the rise ----
        en = 1'b1; imu_decim = 8'd0; exposure_usec = 16'd5;
        run(2);
        clr();
        imu_sync = 1'b1;
        tick();
        chk("basic_sof_first", 32'(sof_stb),     32'd1);
        chk("basic_cam_first", 32'(cam_trigger), 32'd1);
        chk("basic_trig",      32'(trig_cnt),    32'd1);
        tick();
        chk("basic_sof_second", 32'(sof_stb), 32'd0);
        run(38);
        imu_sync = 1'b0;
        run(2);
        chk("basic_width", 32'(hi_acc),    32'd20);
        chk("basic_sofs",  32'(sof_acc),   32'd1);
        chk("basic_trig1", 32'(trig_cnt),  32'd1);

        // ---- decimation by 3, 1 us pulses ----
        do_reset();
        imu_decim = 8'd2; exposure_usec = 16'd1;
        for (int i = 0; i < 9; i++) begin
            clr();
            rise();
            run(49);
            chk($sformatf("decim_rise%0d_width", i + 1), 32'(hi_acc),
                (i % 3 == 2) ? 32'd4 : 32'd0);
        end
        chk("decim_trig", 32'(trig_cnt), 32'd3);

        // ---- selected edge in final EXPOSE cycle, then refire ----
        imu_decim = 8'd0;
        rise();
        run(3);
        rise();
        chk("final_cycle_cam",  32'(cam_trigger), 32'd0);
        chk("final_cycle_miss", 32'(miss_cnt),    32'd1);
        tick();
        rise();
        chk("refire_sof",  32'(sof_stb),  32'd1);
        chk("refire_trig", 32'(trig_cnt), 32'd5);
        wait_idle();

        // ---- zero exposure, then long pulse with overlapping rises ----
        do_reset();
        exposure_usec = 16'd0;
        clr();
        rise();
        run(49);
        chk("zero_exp_width", 32'(hi_acc), 32'd4);
        exposure_usec = 16'd100;
        clr();
        rise();
        chk("long_sof", 32'(sof_stb), 32'd1);
        for (int i = 0; i < 5; i++) begin
            run(39);
            exposure_usec = 16'd7;
            rise();
        end
        run(250);
        chk("long_width", 32'(hi_acc),    32'd400);
        chk("long_rises", 32'(cam_rises), 32'd1);
        chk("long_sofs",  32'(sof_acc),   32'd1);
        chk("long_miss",  32'(miss_cnt),  32'd5);
        chk("long_trig",  32'(trig_cnt),  32'd2);

        // ---- reset mid-pulse ----
        do_reset();
        exposure_usec = 16'd5;
        rise();
        run(7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_cam",  32'(cam_trigger), 32'd0);
        chk("midrst_busy", 32'(busy),        32'd0);
        chk("midrst_trig", 32'(trig_cnt),    32'd0);

        // ---- en dropped mid-pulse ----
        clr();
        rise();
        run(4);
        en = 1'b0;
        run(5);
        rise();
        run(14);
        rise();
        run(14);
        chk("en_off_width", 32'(hi_acc),   32'd20);
        chk("en_off_sofs",  32'(sof_acc),  32'd1);
        chk("en_off_trig",  32'(trig_cnt), 32'd1);
        chk("en_off_miss",  32'(miss_cnt), 32'd0);

        // ---- counter limits ----
        do_reset();
        en = 1'b1; exposure_usec = 16'd100;
        rise();
        force dut.r_miss_cnt = 16'hFFFE;
        tick();
        release dut.r_miss_cnt;
        tick();
        chk("miss_preset", 32'(miss_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            rise();
            run(3);
        end
        chk("miss_sat", 32'(miss_cnt), 32'h0000_FFFF);
        wait_idle();
        force dut.r_trig_cnt = 16'hFFFF;
        tick();
        release dut.r_trig_cnt;
        tick();
        chk("trig_preset", 32'(trig_cnt), 32'h0000_FFFF);
        exposure_usec = 16'd1;
        rise();
        chk("trig_wrap", 32'(trig_cnt), 32'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
